mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for the word-addressed synchronous RAM: 30-bit word address, `wren`, 32-bit write data, read data valid one cycle after the address edge.
- Converts byte-addressed load/store requests into RAM cycles:
  - Sub-word loads use extract plus sign/zero extension.
  - Byte and halfword stores use read-modify-write, because the RAM has no byte enables.
- Sits between the core's MEM stage and the RAM instance. Little-endian byte lanes.

Parameters:
- AW, 30, RAM word-address width (`ram_address` width).

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req  in  1  request strobe; sampled only when `ready`=1
- we  in  1  1=store, 0=load
- size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- sext  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr  in  AW+2  byte address
- wdata  in  32  store data, right-justified
- ready  out  1  unit idle, can accept `req`
- done  out  1  one-cycle pulse: access complete
- rdata  out  32  load result; valid when `done`=1, held until next accept
- err  out  1  one-cycle pulse: misaligned access rejected (only with `MISALIGN_TRAP_EN`)
- ram_wren  out  1  RAM write enable
- ram_address  out  AW  RAM word address
- ram_data  out  32  RAM write data
- ram_q  in  32  RAM read data (for the address registered at the previous edge)

Behaviour:
- Reset: state=IDLE; `ready`=1; `done`=0; `err`=0; `rdata`=0; `ram_wren`=0; `ram_address`=0; `ram_data`=0.
- `ram_wren` is gated with `~rst`, so no RAM write occurs in any cycle where `rst`=1.
- Reset mid-operation abandons the request; no partial write; no `done`.
- Accept: in IDLE with `req`=1, the unit latches `we`, `size`, `sext`, `addr`, `wdata`. `ready`=0 from the next cycle until the return to IDLE.
- `req` while `ready`=0 is ignored; there is no queue.
- `ram_address` = latched `addr[AW+1:2]`, registered, stable for the whole access.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, DONE.
  - Load: IDLE → RD_ADDR → RD_DATA → DONE → IDLE.
    - RD_ADDR presents the address.
    - In RD_DATA, `ram_q` is valid; select a lane by `addr[1:0]` (byte: `q[8k+7:8k]`; half: `addr[1]` selects `q[15:0]` or `q[31:16]`), extend per `sext`, register into `rdata`.
    - `done`=1 in DONE, three cycles after the accept edge.
  - Word store: IDLE → WR → DONE → IDLE.
    - WR: `ram_wren`=1, `ram_data`=`wdata`.
    - `done` two cycles after accept.
  - Sub-word store: IDLE → RD_ADDR → RD_DATA → WR → DONE → IDLE.
    - In RD_DATA, replace the addressed lane(s) of `ram_q` with `wdata[7:0]` or `wdata[15:0]`; other bytes pass through unchanged; register the result into `ram_data`.
    - WR writes it. `done` four cycles after accept.
- `ram_wren` is high only in WR; exactly one write per store.
- DONE always lasts one cycle, then IDLE. Minimum request spacing = latency + 1.
- Stores leave `rdata` unchanged.
- Misalignment: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
- `size`=3 behaves exactly as `size`=2.
- The address wraps naturally at 2^AW words; no bounds check.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined: a misaligned request is accepted from IDLE and goes to DONE with `err`=1 and `done`=0 in that cycle. There is no RAM access, `ram_wren` stays 0, and `rdata` is unchanged.
- Undefined: `err` is tied 0. Low address bits are force-aligned: half ignores `addr[0]`, word ignores `addr[1:0]`. The access then proceeds normally.

Decomposition:
- Shared package `mem_pkg`:
  - Size encodings: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2.
  - FSM state enum.
  - Misalign predicate function.
- One natural combinational sub-module, `lane_merge`: lane extract/extend for loads and lane merge for stores, unit-testable on its own. The FSM stays in the top module.

Test Plan:
- Word store `addr`=0x10, `wdata`=0xDEADBEEF, then word load from 0x10:
  - Store: `ram_wren` for one cycle with `ram_address`=4; `done` two cycles after accept.
  - Load: `rdata`=0xDEADBEEF, `done` three cycles after accept.
- Preload word 4 = 0x11223344. Byte store `addr`=0x12, `wdata`=0xAB:
  - RAM word 4 = 0x11AB3344.
  - `done` four cycles after accept.
  - Exactly one `ram_wren` cycle.
- Word 4 = 0x80FF7F01:
  - Byte load 0x12, `sext`=1 → 0xFFFFFFFF.
  - Byte load 0x11, `sext`=0 → 0x0000007F.
  - Half load 0x12, `sext`=1 → 0xFFFF80FF.
  - Half load 0x10, `sext`=0 → 0x00007F01.
- `req` held high continuously, alternating requests:
  - Each request is accepted only on a cycle with `ready`=1.
  - No request is lost or duplicated; `done` count equals accept count.
- `rst` asserted during WR of a byte store to word 4 (preloaded 0x11223344):
  - Word 4 unchanged.
  - No `done`; `ready`=1 the cycle after `rst` is released.
- Half load `addr`=0x13:
  - With `MISALIGN_TRAP_EN`: `err` pulse, no `ram_wren`, `rdata` unchanged.
  - Without it: reads the half at 0x12.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: size codes, FSM states,
// latched request control and alignment helpers.
package mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Control fields captured when a request is accepted
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sext;
    logic [1:0] lane;
  } acc_ctl_t;

  // The reserved size code behaves as a word access
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd3) ? SZ_WORD : size;
  endfunction

  // Half needs addr[0]=0, word needs addr[1:0]=0
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (norm_size(size))
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = |lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Drop the low address bits that an access of this size ignores
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] lane;
    lane = lo;
    case (norm_size(size))
      SZ_HALF: lane = {lo[1], 1'b0};
      SZ_WORD: lane = 2'b00;
      default: lane = lo;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Byte-lane datapath: extract/extend a loaded lane and merge store data
// into a read word (little-endian lanes).
module lane_merge
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] q,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_c,
  output logic [DATA_W-1:0] merge_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the RAM word
  always_comb begin
    byte_sel = q[7:0];
    case (lane)
      2'd0: byte_sel = q[7:0];
      2'd1: byte_sel = q[15:8];
      2'd2: byte_sel = q[23:16];
      2'd3: byte_sel = q[31:24];
      default: byte_sel = q[7:0];
    endcase
    half_sel = lane[1] ? q[31:16] : q[15:0];
  end

  // Load result with sign or zero extension
  always_comb begin
    load_c = q;
    case (size)
      SZ_BYTE: load_c = {{24{sext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_c = {{16{sext & half_sel[15]}}, half_sel};
      default: load_c = q;
    endcase
  end

  // Store merge: replace only the addressed lane(s)
  always_comb begin
    merge_c = q;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: merge_c[7:0]   = wdata[7:0];
          2'd1: merge_c[15:8]  = wdata[7:0];
          2'd2: merge_c[23:16] = wdata[7:0];
          2'd3: merge_c[31:24] = wdata[7:0];
          default: merge_c = q;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merge_c[31:16] = wdata[15:0];
        else         merge_c[15:0]  = wdata[15:0];
      end
      default: merge_c = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-wide synchronous RAM.
// Sub-word loads extract and extend; sub-word stores read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned requests end with an err pulse and
// no RAM access; otherwise low address bits are force-aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned AW = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [AW+1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              ram_wren,
  output logic [AW-1:0]     ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);

  state_t            state;
  state_t            state_nxt;
  acc_ctl_t          ctl_acc;
  acc_ctl_t          ctl_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic [DATA_W-1:0] load_c;
  logic [DATA_W-1:0] merge_c;
`ifdef MISALIGN_TRAP_EN
  logic              misal_acc;
  logic              misal_q;
`endif

  assign accept = (state == IDLE) && req;

`ifdef MISALIGN_TRAP_EN
  assign misal_acc = is_misaligned(size, addr[1:0]);
`endif

  // Normalise size and lane of the incoming request
  always_comb begin
    ctl_acc      = '0;
    ctl_acc.we   = we;
    ctl_acc.size = norm_size(size);
    ctl_acc.sext = sext;
`ifdef MISALIGN_TRAP_EN
    ctl_acc.lane = addr[1:0];
`else
    ctl_acc.lane = align_lane(size, addr[1:0]);
`endif
  end

  lane_merge u_lane_merge (
    .q       (ram_q),
    .size    (ctl_q.size),
    .sext    (ctl_q.sext),
    .lane    (ctl_q.lane),
    .wdata   (wdata_q),
    .load_c  (load_c),
    .merge_c (merge_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; word stores skip the read phase
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (we && (ctl_acc.size == SZ_WORD)) state_nxt = WR;
          else                                 state_nxt = RD_ADDR;
`ifdef MISALIGN_TRAP_EN
          if (misal_acc) state_nxt = DONE;
`endif
        end
      end
      RD_ADDR: state_nxt = RD_DATA;
      RD_DATA: state_nxt = ctl_q.we ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; the write strobe is killed during reset
  always_comb begin
    ready    = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    ram_wren = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      WR:   ram_wren = ~rst;
      DONE: begin
`ifdef MISALIGN_TRAP_EN
        done = ~misal_q;
        err  = misal_q;
`else
        done = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Request capture, RAM address/data and load result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q       <= '0;
      wdata_q     <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      rdata       <= '0;
`ifdef MISALIGN_TRAP_EN
      misal_q     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        ctl_q       <= ctl_acc;
        wdata_q     <= wdata;
        ram_address <= addr[AW+1:2];
        if (we && (ctl_acc.size == SZ_WORD)) ram_data <= wdata;
`ifdef MISALIGN_TRAP_EN
        misal_q     <= misal_acc;
`endif
      end
      if (state == RD_DATA) begin
        if (ctl_q.we) ram_data <= merge_c;
        else          rdata    <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural synchronous RAM
// and a byte-array reference model.
module tb_mem_access_unit;

  localparam int unsigned AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sext;
  logic [AW+1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic          done;
  logic [31:0]   rdata;
  logic          err;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data;
  logic [31:0]   ram_q;
  logic          ram_clear;

  logic [31:0] mem  [0:63];
  logic [7:0]  bmem [0:255];

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int          lat;
    logic        err;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;

  typedef struct packed {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
  } stim_t;

  exp_t exp_q[$];
  int   acc_q[$];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          acc_cnt  = 0;
  int          done_cnt = 0;
  int          pushed   = 0;
  int          wr_cnt   = 0;
  int          wr_total = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] model_rdata  = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .we          (we),
    .size        (size),
    .sext        (sext),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .done        (done),
    .rdata       (rdata),
    .err         (err),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  // Synchronous RAM, read data one cycle after the address edge
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) mem[6'(ram_address)] <= ram_data;
      ram_q <= mem[6'(ram_address)];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", tag, act, expv);
    end
  endtask

  // Reference model on a byte array; fills in the expected completion
  task automatic model_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] d, output exp_t e);
    int          n;
    int          base;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[7:0]);
    e.is_load = !w;
    e.err     = 1'b0;
    e.nwr     = 0;
    e.waddr   = 32'(a[31:2]);
    e.rdata   = model_rdata;
    e.lat     = 0;
`ifdef MISALIGN_TRAP_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
      e.err = 1'b1;
      e.lat = 1;
      return;
    end
`endif
    base = base & ~(n - 1);
    if (w) begin
      for (int k = 0; k < n; k++) bmem[base + k] = d[8*k +: 8];
      e.nwr = 1;
      e.lat = (n == 4) ? 2 : 4;
    end else begin
      v = '0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = bmem[base + k];
      if (sx && v[8*n-1]) for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      model_rdata = v;
      e.rdata = v;
      e.lat = 3;
    end
  endtask

  // Drive one request, push its expectation, wait for it to be taken
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input logic hold);
    exp_t e;
    bit   got;
    model_access(w, sz, sx, a, d, e);
    we = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
    exp_q.push_back(e);
    pushed++;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Completion monitor: pops the scoreboard on done/err
  always @(negedge clk) begin
    exp_t e;
    int   ca;
    if (rst) begin
      acc_q.delete();
    end else begin
      if (ram_wren) begin
        wr_cnt++;
        wr_total++;
        last_wr_addr = 32'(ram_address);
      end
      if (done || err) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e  = exp_q.pop_front();
          ca = acc_q.pop_front();
          done_cnt++;
          check("latency", 32'(cyc - ca), 32'(e.lat));
          check("rdata", rdata, e.rdata);
          check("err", 32'(err), 32'(e.err));
          check("done_vs_err", 32'(done), 32'(!e.err));
          check("wren_count", 32'(wr_cnt), 32'(e.nwr));
          if (e.nwr == 1) check("wr_address", last_wr_addr, e.waddr);
        end
      end
      if (req && ready) begin
        acc_q.push_back(cyc);
        acc_cnt++;
        wr_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    stim_t seq [8];
    bit    got;
    int    wr_before;
    int    done_before;

    rst = 1'b1; ram_clear = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0;
    sext = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) bmem[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_address", 32'(ram_address), 32'd0);
    check("rst_ram_data", ram_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; ram_clear = 1'b0;

    // Word store then word load
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0); wait_idle();
    check("mem4_word", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();

    // Byte store read-modify-write
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0); wait_idle();
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, 1'b0); wait_idle();
    check("mem4_rmw", mem[4], 32'h11AB3344);

    // Sub-word loads with extension, plus reserved size
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 1'b0); wait_idle();
    issue(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 1'b0); wait_idle();
    check("lb_sext", rdata, 32'hFFFFFFFF);
    issue(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0); wait_idle();
    check("lbu", rdata, 32'h0000007F);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0); wait_idle();
    check("lh_sext", rdata, 32'hFFFF80FF);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    check("lhu", rdata, 32'h00007F01);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0); wait_idle();

    // Back-to-back requests with req held high
    seq[0] = '{1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D};
    seq[1] = '{1'b0, 2'd0, 1'b1, 32'h21, 32'h0};
    seq[2] = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234};
    seq[3] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0};
    seq[4] = '{1'b1, 2'd0, 1'b0, 32'h23, 32'h00000099};
    seq[5] = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0};
    seq[6] = '{1'b1, 2'd2, 1'b0, 32'h2E, 32'h5A5A0F0F};
    seq[7] = '{1'b0, 2'd3, 1'b0, 32'h2C, 32'h0};
    for (int i = 0; i < 8; i++)
      issue(seq[i].w, seq[i].sz, seq[i].sx, seq[i].a, seq[i].d, (i != 7));
    wait_idle();

    // Reset while a byte store is in its write cycle
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0); wait_idle();
    wr_before   = wr_total;
    done_before = done_cnt;
    we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h12; wdata = 32'h000000CD; req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = ready;
    end
    if (!got) check("accept_timeout_rst", 32'd0, 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = '0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);
    repeat (4) @(negedge clk);
    check("mem4_after_rst", mem[4], 32'h11223344);
    check("no_write_in_rst", 32'(wr_total), 32'(wr_before));
    check("no_done_in_rst", 32'(done_cnt), 32'(done_before));
    @(posedge clk); #1;

    // Misaligned half load
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0); wait_idle();
    issue(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0); wait_idle();
`ifdef MISALIGN_TRAP_EN
    check("misalign_rdata_kept", rdata, 32'h11223344);
`else
    check("misalign_half", rdata, 32'h00001122);
`endif

    // Final RAM image against the byte model, and request accounting
    for (int w = 0; w < 16; w++)
      check("ram_image", mem[w], {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]});
    check("done_count", 32'(done_cnt), 32'(pushed));
    check("accept_count", 32'(acc_cnt), 32'(pushed + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
